// File: rtl/cpu_pkg.sv
// Shared fetch-side definitions: next-PC operation codes, sequencer states
// and the default reset vector.
package cpu_pkg;

    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_JMP = 2'b10;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } pc_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry instruction holding register used while IF/ID is stalled.
module if_skid_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] din,
    output logic        valid,
    output logic [31:0] dout
);

    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            data_d  = din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign dout  = data_q;

endmodule

// File: rtl/pc_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues imem requests, defers redirects
// past the in-flight delay-slot fetch and holds one instruction across stalls.
module pc_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        id_valid,
    input  logic [1:0]  id_npcop,
    input  logic        br_taken,
    input  logic [31:0] npc_addr,
    output logic [1:0]  npcop,
    output logic [31:0] pc,
    output logic [31:0] pcplus,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] redir_addr_q, redir_addr_d;

    logic        redir;
    logic [31:0] npc_aligned;
    logic        buf_load, buf_clear, buf_valid;
    logic [31:0] buf_data;

    assign pc     = pc_q;
    assign pcplus = pc_q + 32'd4;

    always_comb begin
        redir        = id_valid & ((id_npcop == NPC_JMP) |
                                   ((id_npcop == NPC_BR) & br_taken));
        npcop        = redir ? id_npcop : NPC_SEQ;
        npc_aligned  = {npc_addr[31:2], 2'b00};

        state_d      = state_q;
        pc_d         = pc_q;
        redir_pend_d = redir_pend_q;
        redir_addr_d = redir_addr_q;
        imem_req     = 1'b0;
        if_valid     = 1'b0;
        if_instr     = '0;
        buf_load     = 1'b0;
        buf_clear    = 1'b0;

        case (state_q)
            ST_RESET: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    // The completing fetch is the delay slot; a deferred
                    // redirect takes priority over one resolved this cycle.
                    if (redir_pend_q) begin
                        pc_d         = redir_addr_q;
                        redir_pend_d = 1'b0;
                    end else if (redir) begin
                        pc_d = npc_aligned;
                    end else begin
                        pc_d = pcplus;
                    end
                    if (stall) begin
                        buf_load = 1'b1;
                        state_d  = ST_HOLD;
                    end else begin
                        if_valid = 1'b1;
                        if_instr = imem_rdata;
                    end
                end else if (redir && !redir_pend_q) begin
                    redir_pend_d = 1'b1;
                    redir_addr_d = npc_aligned;
                end
            end
            ST_HOLD: begin
                if_valid = buf_valid;
                if_instr = buf_data;
                if (redir && !redir_pend_q) begin
                    redir_pend_d = 1'b1;
                    redir_addr_d = npc_aligned;
                end
                if (!stall) begin
                    buf_clear = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RESET;
            pc_q         <= RESET_PC;
            redir_pend_q <= 1'b0;
            redir_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redir_pend_q <= redir_pend_d;
            redir_addr_q <= redir_addr_d;
        end
    end

    if_skid_buf u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (buf_load),
        .clear (buf_clear),
        .din   (imem_rdata),
        .valid (buf_valid),
        .dout  (buf_data)
    );

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl with a scoreboard of expected IF/ID instructions.
module tb_pc_ctrl;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        id_valid = 1'b0;
    logic [1:0]  id_npcop = 2'b00;
    logic        br_taken = 1'b0;
    logic [31:0] npc_addr = 32'd0;
    logic [1:0]  npcop;
    logic [31:0] pc;
    logic [31:0] pcplus;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;

    logic        ovr_en = 1'b0;
    logic [31:0] ovr_val = 32'd0;
    logic [31:0] epc;
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    // Memory returns a word derived from the requested address unless overridden.
    always_comb imem_rdata = ovr_en ? ovr_val : (pc ^ 32'hC0DE_0000);

    pc_ctrl #(.RESET_PC(32'h0000_3000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .id_valid   (id_valid),
        .id_npcop   (id_npcop),
        .br_taken   (br_taken),
        .npc_addr   (npc_addr),
        .npcop      (npcop),
        .pc         (pc),
        .pcplus     (pcplus),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_instr   (if_instr)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop on negedge, then advance to just after the next rising edge.
    task automatic step();
        @(negedge clk);
        if (if_valid === 1'b1 && stall === 1'b0) begin
            if (exp_q.size() == 0)
                chk("sb_unexpected_valid", 32'(if_valid), 32'd0);
            else
                chk("sb_if_instr", if_instr, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"}, pc, 32'h0000_3000);
        chk({tag, "_pcplus"}, pcplus, 32'h0000_3004);
        chk({tag, "_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_if_valid"}, 32'(if_valid), 32'd0);
        chk({tag, "_if_instr"}, if_instr, 32'd0);
        chk({tag, "_npcop"}, 32'(npcop), 32'd0);
        chk({tag, "_pend"}, 32'(dut.redir_pend_q), 32'd0);
    endtask

    initial begin
        // Reset and release
        #1 rst_n = 1'b0;
        #2;
        chk_reset_vals("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("req_after_release", 32'(imem_req), 32'd0);
        step();
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_pc", pc, 32'h0000_3000);

        // Zero-wait sequential fetch
        imem_ack = 1'b1;
        epc = 32'h0000_3000;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("seq_pc", pc, epc);
            chk("seq_npcop", 32'(npcop), 32'd0);
            chk("seq_if_valid", 32'(if_valid), 32'd1);
            exp_q.push_back(mem_word(epc));
            step();
            epc = epc + 32'd4;
        end

        // Taken branch with zero-wait memory, unaligned target
        id_valid = 1'b1; id_npcop = 2'b01; br_taken = 1'b1; npc_addr = 32'h0000_3043;
        #1;
        chk("br_npcop", 32'(npcop), 32'd1);
        chk("br_pc", pc, 32'h0000_3010);
        exp_q.push_back(mem_word(32'h0000_3010));
        step();
        br_taken = 1'b0; npc_addr = 32'h0000_3200;
        #1;
        chk("br_target_pc", pc, 32'h0000_3040);
        chk("br_nt_npcop", 32'(npcop), 32'd0);
        exp_q.push_back(mem_word(32'h0000_3040));
        step();
        id_valid = 1'b0; id_npcop = 2'b00;
        #1;
        chk("br_nt_pc", pc, 32'h0000_3044);

        // Jump resolved during a 3-cycle fetch
        imem_ack = 1'b0; id_valid = 1'b1; id_npcop = 2'b10; npc_addr = 32'h0000_3100;
        #1;
        chk("jmp_npcop", 32'(npcop), 32'd2);
        chk("jmp_wait_if_valid", 32'(if_valid), 32'd0);
        step();
        id_valid = 1'b0; stall = 1'b1;
        #1;
        chk("jmp_pend_set", 32'(dut.redir_pend_q), 32'd1);
        chk("jmp_wait_pc", pc, 32'h0000_3044);
        chk("jmp_wait_req", 32'(imem_req), 32'd1);
        step();
        stall = 1'b0; imem_ack = 1'b1; id_valid = 1'b1; npc_addr = 32'h0000_3300;
        #1;
        chk("jmp_ack_pc", pc, 32'h0000_3044);
        exp_q.push_back(mem_word(32'h0000_3044));
        step();
        id_valid = 1'b0; id_npcop = 2'b00;
        #1;
        chk("jmp_target_pc", pc, 32'h0000_3100);
        chk("jmp_pend_clr", 32'(dut.redir_pend_q), 32'd0);

        // Stall on ack: hold buffered instruction, redirect arrives in HOLD
        stall = 1'b1; ovr_en = 1'b1; ovr_val = 32'h2402_0005;
        #1;
        step();
        imem_ack = 1'b0; ovr_en = 1'b0;
        #1;
        chk("hold_state", 32'(dut.state_q), 32'(ST_HOLD));
        chk("hold_req", 32'(imem_req), 32'd0);
        chk("hold_if_valid", 32'(if_valid), 32'd1);
        chk("hold_instr", if_instr, 32'h2402_0005);
        chk("hold_pc", pc, 32'h0000_3104);
        step();
        id_valid = 1'b1; id_npcop = 2'b10; npc_addr = 32'h0000_3400;
        #1;
        chk("hold2_instr", if_instr, 32'h2402_0005);
        chk("hold2_npcop", 32'(npcop), 32'd2);
        step();
        id_valid = 1'b0; id_npcop = 2'b00; stall = 1'b0;
        exp_q.push_back(32'h2402_0005);
        #1;
        chk("release_req", 32'(imem_req), 32'd0);
        chk("hold_pend", 32'(dut.redir_pend_q), 32'd1);
        step();
        #1;
        chk("refetch_req", 32'(imem_req), 32'd1);
        chk("refetch_pc", pc, 32'h0000_3104);
        imem_ack = 1'b1;
        exp_q.push_back(mem_word(32'h0000_3104));
        step();
        imem_ack = 1'b0;
        #1;
        chk("hold_redir_pc", pc, 32'h0000_3400);

        // Reset during a pending fetch with a deferred redirect
        id_valid = 1'b1; id_npcop = 2'b10; npc_addr = 32'h0000_3500;
        #1;
        step();
        id_valid = 1'b0; id_npcop = 2'b00;
        #1;
        chk("prerst_pend", 32'(dut.redir_pend_q), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        imem_ack = 1'b1;
        step();
        #1;
        chk("inrst_pc", pc, 32'h0000_3000);
        chk("inrst_req", 32'(imem_req), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("late_ack_if_valid", 32'(if_valid), 32'd0);
        chk("late_ack_req", 32'(imem_req), 32'd0);
        step();
        imem_ack = 1'b0;
        #1;
        chk("restart_pc", pc, 32'h0000_3000);
        chk("restart_req", 32'(imem_req), 32'd1);
        chk("restart_pend", 32'(dut.redir_pend_q), 32'd0);
        imem_ack = 1'b1;
        exp_q.push_back(mem_word(32'h0000_3000));
        step();

        // Wrap at the top of the address space
        #1;
        chk("wrap_pre_pc", pc, 32'h0000_3004);
        id_valid = 1'b1; id_npcop = 2'b10; npc_addr = 32'hFFFF_FFFF;
        exp_q.push_back(mem_word(32'h0000_3004));
        step();
        id_valid = 1'b0; id_npcop = 2'b00;
        #1;
        chk("wrap_pc_top", pc, 32'hFFFF_FFFC);
        chk("wrap_pcplus", pcplus, 32'h0000_0000);
        exp_q.push_back(mem_word(32'hFFFF_FFFC));
        step();
        imem_ack = 1'b0;
        #1;
        chk("wrap_pc_zero", pc, 32'h0000_0000);
        chk("wrap_pcplus_zero", pcplus, 32'h0000_0004);
        step();

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Fetch-stage sequencer that owns the program counter and drives the `npc` next-address datapath. It issues instruction-memory requests over a req/ack handshake and selects the `npcop` for each PC update. It holds a redirect (branch/jump) resolved in ID until the in-flight delay-slot fetch completes, and buffers one fetched instruction when the hazard unit stalls IF/ID. It sits between the hazard unit, the ID-stage branch logic, instruction memory and the IF/ID pipeline register.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value after reset; word aligned.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard unit: IF/ID must not advance this cycle.
- `id_valid`  in  1  ID stage holds a valid instruction this cycle.
- `id_npcop`  in  2  decoded control-flow class: 00 sequential, 01 conditional branch, 10 jump/jr.
- `br_taken`  in  1  branch condition result; qualifies `id_npcop`==01.
- `npc_addr`  in  32  address returned by `npc` for the `npcop` driven this cycle.
- `npcop`  out  2  to `npc`.
- `pc`  out  32  current fetch PC.
- `pcplus`  out  32  `pc`+4, to `npc`.
- `imem_req`  out  1  fetch request; address is `pc`.
- `imem_ack`  in  1  fetch complete; `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  fetched instruction.
- `if_valid`  out  1  `if_instr` is valid for IF/ID capture.
- `if_instr`  out  32  instruction to IF/ID.

## Operation
- Effective redirect this cycle: `redir` = `id_valid` & (`id_npcop`==10 | (`id_npcop`==01 & `br_taken`)).
- `npcop` = `redir` ? `id_npcop` : 00. It is combinational and also driven while the PC is not updating, so `npc_addr` can be latched.
- States:
  - RESET: entered on `rst_n`=0. One cycle with no request after release, then FETCH.
  - FETCH: `imem_req`=1. On `imem_ack`:
    - If `stall`=0: `if_valid`=1 and `if_instr`=`imem_rdata` (pass-through), and the PC updates.
    - If `stall`=1: store `imem_rdata` in the buffer, update the PC, go to HOLD.
  - HOLD: `imem_req`=0, `if_valid`=1, `if_instr`=buffer. When `stall`=0 the buffer is consumed that cycle and the state returns to FETCH.
- PC update source, evaluated on the cycle of `imem_ack`:
  - pending redirect → `redir_addr`;
  - else `redir` this cycle → `npc_addr`;
  - else `pcplus`.
  - This is delay-slot semantics: the fetch in flight when the branch resolves is the delay slot.
- Pending redirect:
  - If `redir`=1 in a cycle without `imem_ack`, or while in HOLD, latch `redir_addr`←`npc_addr` and set `redir_pend`.
  - Cleared when consumed by a PC update.
  - A second `redir` while pending is ignored; ID cannot present two control transfers within one delay slot.
- `stall`=1 with no ack in FETCH: the request stays asserted and `pc` holds.
- Arithmetic: `pcplus` = `pc`+32'd4, wrapping modulo 2^32. `pc[1:0]` is always 00; any `npc_addr[1:0]` is forced to 00 on load.

## Timing
- Reset values: `pc`=`RESET_PC`, `pcplus`=`RESET_PC`+4, `imem_req`=0, `if_valid`=0, `if_instr`=0, `npcop`=00, `redir_pend`=0, state RESET.
- First `imem_req` occurs in the second rising edge after `rst_n` deasserts.
- With a zero-wait memory (ack in the same cycle as req) and no stall: one instruction per cycle, and `pc` advances on every edge.
- Memory latency N cycles: `imem_req` is held N cycles, and `pc` is stable until the edge after ack.
- Reset mid-fetch: the outstanding request is abandoned, the buffer and pending redirect are cleared, and a late `imem_ack` during RESET is ignored.
- Simultaneous `imem_ack` and `redir` with no pending redirect: `npc_addr` is loaded directly and nothing is latched.

## Structure
- Shared package `cpu_pkg`:
  - `npcop` encodings NPC_SEQ=2'b00, NPC_BR=2'b01, NPC_JMP=2'b10;
  - state encoding;
  - default reset PC constant.
- One natural sub-module: `if_skid_buf`, the one-entry instruction holding register with valid bit. The state machine, PC register and redirect latch stay in `pc_ctrl`.

## Test plan
- Reset release, ack tied high, no stall, no redirect → `pc` sequence 0x3000, 0x3004, 0x3008…, `if_valid` high from the first fetch cycle, `npcop`=00 throughout.
- Branch at 0x3000 taken while fetching 0x3004, zero-wait → `npcop`=01 in that cycle, `npc_addr`=0x3040 loaded, following fetches 0x3040, 0x3044.
- Jump resolved while a 3-cycle fetch of 0x3008 is in flight, `npc_addr`=0x3100 → `redir_pend`=1, fetch of 0x3008 completes, next `pc`=0x3100, pending cleared.
- `stall` high when ack returns instruction 0x2402_0005 → state HOLD, `imem_req`=0, `if_instr`=0x2402_0005 held for 2 stall cycles, released once, next request issued the following cycle.
- `rst_n` pulsed low during a pending fetch with `redir_pend`=1 → all outputs return to reset values, a late ack is ignored, restart from 0x3000.
- `pc`=0xFFFF_FFFC sequential → `pcplus`=0x0000_0000, and the next `pc` wraps to 0.
